ps2_key_scheduler: RTL
======================

# ps2_key_scheduler

Sits between the PS/2 keyboard decoder and the game core. Turns the decoder's held-key levels (up/down/left/right/enter) into a stream of discrete commands. Arbitrates simultaneous direction keys with last-pressed-wins, generates auto-repeat for a held direction, and buffers commands in a 2-entry FIFO behind a valid/ready handshake.

## Interface
- DELAY_CYC, 25_000_000: cycles from a direction's initial command to its first repeat (250 ms at 100 MHz); must be ≥ 2.
- RATE_CYC, 10_000_000: cycles between subsequent repeats; must be ≥ 2.
- CNT_W, 25: repeat counter width; 2^CNT_W must exceed max(DELAY_CYC, RATE_CYC).

- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous, active-low.
- key_up, key_down, key_left, key_right, key_enter  in  1 each  held-key levels, synchronous to clk.
- cmd_valid  out  1  FIFO non-empty.
- cmd_code  out  3  head command: 0 UP, 1 DOWN, 2 LEFT, 3 RIGHT, 4 ENTER.
- cmd_ready  in  1  consumer accepts head when cmd_valid && cmd_ready.
- held_valid  out  1  a direction is currently active.
- held_dir  out  2  active direction, coded as cmd_code 0-3.
- overflow  out  1  one-cycle pulse: a command was dropped.

## Operation
- Edge detection:
  - One prev register per key, reset 0.
  - A press is key && !prev.
  - Keys already high when reset releases register as presses in the first cycle after reset.
- Direction arbitration, evaluated every cycle:
  - Direction presses this cycle: the winner is the highest-priority pressed key, UP > DOWN > LEFT > RIGHT. It becomes active.
  - No press, active key still held: the active direction is kept.
  - No press, active key released: the highest-priority still-held direction becomes active; if none is held, held_valid goes to 0.
- Repeat FSM, states IDLE, DELAY, REPEAT; counter cnt:
  - Active direction changes, including IDLE to active: push that direction, cnt <= 0, go to DELAY.
  - DELAY: cnt increments; at cnt == DELAY_CYC-1, push the active direction, cnt <= 0, go to REPEAT.
  - REPEAT: cnt increments; at cnt == RATE_CYC-1, push the active direction, cnt <= 0.
  - held_valid 0, from any state: go to IDLE, cnt <= 0, no push.
- Enter: a press of key_enter pushes ENTER once; it never repeats and does not affect direction state.
- FIFO, 2 entries, head = oldest entry:
  - A pop occurs when cmd_valid && cmd_ready.
  - Up to two pushes per cycle (ENTER and a direction). ENTER is ordered first.
  - Free slots = 2 - count + (pop ? 1 : 0).
  - Pushes beyond the free slots are dropped in order: the direction push is dropped before ENTER.
  - Any drop asserts overflow for that cycle's following cycle (registered).
  - A simultaneous push and pop when full is accepted, and count stays 2.
  - While cmd_valid is high and no pop occurs, cmd_code is stable.

## Timing
- All outputs are registered.
- Reset values:
  - cmd_valid 0, cmd_code 0, held_valid 0, held_dir 0, overflow 0.
  - FIFO empty, FSM in IDLE, cnt 0, all prev registers 0.
- A press sampled in cycle N appears as cmd_valid/cmd_code in cycle N+1 when the FIFO has room; held_valid/held_dir update in N+1.
- Repeat pushes:
  - First repeat push occurs DELAY_CYC cycles after the initial push.
  - Later repeat pushes occur every RATE_CYC cycles.
  - Each repeat is visible one cycle after its push.
- A pop in cycle N presents the next entry (or cmd_valid 0) in N+1.
- Release of the last held direction in cycle N: held_valid is 0 in N+1 and no further repeat push occurs.
- Asserting rst_n low mid-operation clears all state immediately, including pending FIFO entries and the overflow pulse.

## Test plan
- Press then release, DELAY_CYC=8, RATE_CYC=4, cmd_ready=1:
  - Stimulus: key_left high for 1 cycle, then low.
  - Required: exactly one cmd_code 2 with a single-cycle cmd_valid; held_valid is 1 for one cycle.
- Auto-repeat, same parameters:
  - Stimulus: key_up held for 20 cycles.
  - Required: cmd_code 0 pushes at relative cycles 0, 8, 12, 16; none after release; FSM returns to IDLE.
- Last-pressed-wins and fallback:
  - Stimulus: hold key_right, then 3 cycles later press key_down, then release key_down.
  - Required: pushes RIGHT, DOWN, then RIGHT again; held_dir goes 3, 1, 3.
- Simultaneous press:
  - Stimulus: key_left and key_up rise in the same cycle as key_enter, cmd_ready=1.
  - Required: ENTER (4) then UP (0); held_dir=0.
- Backpressure and overflow:
  - Stimulus: cmd_ready=0; press UP, then DOWN, then LEFT.
  - Required: FIFO holds UP, DOWN; LEFT dropped with a 1-cycle overflow pulse; cmd_code stays 0 until cmd_ready rises, then pops yield 0, 1.
- Reset mid-hold:
  - Stimulus: assert rst_n low while key_up is held and the FIFO holds 1 entry.
  - Required: all outputs 0 immediately; after release, a fresh UP push occurs one cycle later.

Source files
------------

// File: rtl/ps2_key_scheduler.sv
// ps2_key_scheduler
// Turns held-key levels from the PS/2 decoder into discrete game commands.
// Direction keys are arbitrated last-pressed-wins, the active direction
// auto-repeats, and commands are queued in a 2-entry FIFO behind a
// valid/ready handshake. ENTER is a one-shot command on each press.
module ps2_key_scheduler #(
    parameter int DELAY_CYC = 25_000_000,
    parameter int RATE_CYC  = 10_000_000,
    parameter int CNT_W     = 25
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_up,
    input  logic       key_down,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_enter,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    input  logic       cmd_ready,
    output logic       held_valid,
    output logic [1:0] held_dir,
    output logic       overflow
);

    // Repeat FSM states
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    localparam logic [2:0] CODE_ENTER = 3'd4;

    // Terminal counts of the repeat counter
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(DELAY_CYC - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(RATE_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);

    // Highest-priority set bit: bit 0 (UP) wins over 1 (DOWN), 2 (LEFT), 3 (RIGHT)
    function automatic logic [1:0] prio_dir(input logic [3:0] v);
        logic [1:0] d;
        if (v[0]) begin
            d = 2'd0;
        end else if (v[1]) begin
            d = 2'd1;
        end else if (v[2]) begin
            d = 2'd2;
        end else begin
            d = 2'd3;
        end
        return d;
    endfunction

    // Key levels indexed by direction code, so bit i corresponds to cmd_code i
    logic [3:0]       dir_keys_s;
    logic [3:0]       dir_press_s;
    logic             enter_press_s;

    logic [4:0]       prev_r;           // {enter, right, left, down, up}
    logic             held_valid_r;
    logic [1:0]       held_dir_r;
    logic [1:0]       state_r;
    logic [CNT_W-1:0] cnt_r;

    logic             next_valid_s;
    logic [1:0]       next_dir_s;
    logic             dir_change_s;
    logic [1:0]       state_n_s;
    logic [CNT_W-1:0] cnt_n_s;
    logic             dir_push_s;

    logic [2:0]       slot0_r;          // head (oldest)
    logic [2:0]       slot1_r;
    logic [1:0]       count_r;
    logic             cmd_valid_r;
    logic             overflow_r;

    logic             pop_s;
    logic [2:0]       slot0_n_s;
    logic [2:0]       slot1_n_s;
    logic [1:0]       count_n_s;
    logic             drop_s;

    assign dir_keys_s    = {key_right, key_left, key_down, key_up};
    assign dir_press_s   = dir_keys_s & ~prev_r[3:0];
    assign enter_press_s = key_enter & ~prev_r[4];

    // Direction arbitration: new presses win, else keep active, else fall back
    always_comb begin
        next_valid_s = 1'b0;
        next_dir_s   = held_dir_r;
        if (|dir_press_s) begin
            next_valid_s = 1'b1;
            next_dir_s   = prio_dir(dir_press_s);
        end else if (held_valid_r && dir_keys_s[held_dir_r]) begin
            next_valid_s = 1'b1;
            next_dir_s   = held_dir_r;
        end else if (|dir_keys_s) begin
            next_valid_s = 1'b1;
            next_dir_s   = prio_dir(dir_keys_s);
        end else begin
            next_valid_s = 1'b0;
            next_dir_s   = held_dir_r;
        end
    end

    assign dir_change_s = next_valid_s && (!held_valid_r || (next_dir_s != held_dir_r));

    // Repeat FSM: initial push on change, first repeat after DELAY, then every RATE
    always_comb begin
        state_n_s  = state_r;
        cnt_n_s    = cnt_r;
        dir_push_s = 1'b0;
        if (!next_valid_s) begin
            state_n_s = ST_IDLE;
            cnt_n_s   = CNT_ZERO;
        end else if (dir_change_s) begin
            dir_push_s = 1'b1;
            cnt_n_s    = CNT_ZERO;
            state_n_s  = ST_DELAY;
        end else begin
            case (state_r)
                ST_DELAY: begin
                    if (cnt_r == DELAY_LAST) begin
                        dir_push_s = 1'b1;
                        cnt_n_s    = CNT_ZERO;
                        state_n_s  = ST_REPEAT;
                    end else begin
                        cnt_n_s = cnt_r + CNT_ONE;
                    end
                end
                ST_REPEAT: begin
                    if (cnt_r == RATE_LAST) begin
                        dir_push_s = 1'b1;
                        cnt_n_s    = CNT_ZERO;
                    end else begin
                        cnt_n_s = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    // Active direction without a running FSM cannot occur; park safely
                    state_n_s = ST_IDLE;
                    cnt_n_s   = CNT_ZERO;
                end
            endcase
        end
    end

    // FIFO update: pop first, then append ENTER before the direction, drop excess
    always_comb begin
        pop_s     = cmd_valid_r && cmd_ready;
        slot0_n_s = slot0_r;
        slot1_n_s = slot1_r;
        count_n_s = count_r;
        drop_s    = 1'b0;
        if (pop_s) begin
            slot0_n_s = slot1_r;
            count_n_s = count_r - 2'd1;
        end else begin
            count_n_s = count_r;
        end
        if (enter_press_s) begin
            if (count_n_s == 2'd0) begin
                slot0_n_s = CODE_ENTER;
                count_n_s = 2'd1;
            end else if (count_n_s == 2'd1) begin
                slot1_n_s = CODE_ENTER;
                count_n_s = 2'd2;
            end else begin
                drop_s = 1'b1;
            end
        end else begin
            drop_s = drop_s;
        end
        if (dir_push_s) begin
            if (count_n_s == 2'd0) begin
                slot0_n_s = {1'b0, next_dir_s};
                count_n_s = 2'd1;
            end else if (count_n_s == 2'd1) begin
                slot1_n_s = {1'b0, next_dir_s};
                count_n_s = 2'd2;
            end else begin
                drop_s = 1'b1;
            end
        end else begin
            drop_s = drop_s;
        end
    end

    // Key history and direction/repeat state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_r       <= 5'd0;
            held_valid_r <= 1'b0;
            held_dir_r   <= 2'd0;
            state_r      <= ST_IDLE;
            cnt_r        <= CNT_ZERO;
        end else begin
            prev_r       <= {key_enter, dir_keys_s};
            held_valid_r <= next_valid_s;
            held_dir_r   <= next_dir_s;
            state_r      <= state_n_s;
            cnt_r        <= cnt_n_s;
        end
    end

    // FIFO storage, registered valid flag and overflow pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_r     <= 3'd0;
            slot1_r     <= 3'd0;
            count_r     <= 2'd0;
            cmd_valid_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            slot0_r     <= slot0_n_s;
            slot1_r     <= slot1_n_s;
            count_r     <= count_n_s;
            cmd_valid_r <= (count_n_s != 2'd0);
            overflow_r  <= drop_s;
        end
    end

    assign cmd_valid  = cmd_valid_r;
    assign cmd_code   = slot0_r;
    assign held_valid = held_valid_r;
    assign held_dir   = held_dir_r;
    assign overflow   = overflow_r;

endmodule
